seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Multi-cycle unsigned 64x64 multiplier for the LegV8 datapath; produces the 128-bit product for MUL (low half) and UMULH (high half).
- Sits beside the ALU, downstream of the operand/register-read stage.
- Radix-2 shift-and-add: one conditional 64-bit add plus one 1-bit right shift per cycle.
- Reuses the same add/shift primitives as the combinational logic modules.
- Start/done handshake to the control unit, which stalls while busy.

Parameters:
- N, 64, operand width in bits; product is 2N bits; iteration count equals N.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled on the rising edge of clock when the FSM is in IDLE or DONE
- A  input  N  multiplicand, captured when start is accepted
- B  input  N  multiplier, captured when start is accepted
- busy  output  1  high while iterations are in progress
- done  output  1  one-cycle pulse; result registers updated this cycle
- product_lo  output  N  low N bits of the last completed product (MUL result)
- product_hi  output  N  high N bits of the last completed product (UMULH result)

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; busy=0, done=0; product_lo=0, product_hi=0.
  - Internal accumulator and counter are cleared.
  - Reset overrides start in the same cycle.
  - Reset during BUSY aborts the operation; no done pulse follows.
- Internal state:
  - Multiplicand register M (N bits).
  - Accumulator {H (N bits), L (N bits)}.
  - Iteration counter: ceil(log2(N+1)) bits.
  - Result registers driving product_hi/product_lo.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: busy=0, done=0. On start=1: M<=A, H<=0, L<=B, counter<=N, go to BUSY.
  - BUSY: busy=1, done=0; start is ignored. Each cycle:
    - sum = H + (L[0] ? M : 0), computed N+1 bits wide (carry kept).
    - {H, L} <= {sum, L} >> 1; the carry enters the MSB of H.
    - counter decrements.
    - When counter reaches 1 during a step (the Nth step), go to DONE and load product_hi/product_lo from the post-step {H, L}.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE and goes directly to BUSY (back-to-back operation); otherwise go to IDLE.
- Latency:
  - start high in cycle t: busy high in cycles t+1..t+N, done high in cycle t+N+1.
  - product outputs show the new value from cycle t+N+1.
  - Throughput: one result per N+1 cycles.
- Result holding:
  - product_hi/product_lo change only at completion or on reset.
  - During BUSY they keep the previous result.
- Arithmetic:
  - Unsigned only; the result is exact, with no overflow or truncation across the full 2N bits.
  - The carry out of the N-bit add is never dropped.
- Operands:
  - A and B are don't-care except in the accept cycle.
  - Changing them during BUSY has no effect.
- start held high continuously: one operation is accepted every N+1 cycles (accept in IDLE/DONE only).

Test Plan:
- Basic: reset, then A=3, B=5, start for 1 cycle -> busy for 64 cycles; done pulse in cycle t+65; product_lo=15, product_hi=0.
- Max operands: A=B=0xFFFFFFFFFFFFFFFF -> product_hi=0xFFFFFFFFFFFFFFFE, product_lo=0x0000000000000001; confirms carry retention.
- Zero and identity:
  - A=0, B=0x123456789ABCDEF0 -> product 0.
  - Then A=0x8000000000000000, B=2 -> product_hi=1, product_lo=0.
- Start while busy:
  - Op1 A=7, B=6; pulse start with A=9, B=9 during cycle t+10.
  - Single done at t+65 with 42; no second done.
  - Result holds 42 until the next accepted start.
- Back-to-back:
  - Op1 A=10, B=10; start=1 in the DONE cycle with A=2, B=3.
  - done with 100, then busy next cycle, then done exactly 65 cycles later with 6.
- Reset mid-operation:
  - Start A=B=0xFFFF; assert reset at cycle t+20 for 1 cycle.
  - busy=0, done=0, products=0 next cycle; no done pulse.
  - A fresh A=4, B=4 then yields 16 with nominal latency.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle unsigned NxN radix-2 shift-and-add multiplier.
// Ports: clock/reset (sync, active-high), start, A, B -> busy, done,
//        product_lo (MUL), product_hi (UMULH).
module seq_multiplier #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product_lo,
    output logic [N-1:0] product_hi
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  mcand;
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;
    logic [CW-1:0] count;

    logic [N:0]    sum;
    logic [N-1:0]  addend;
    logic [N-1:0]  step_hi;
    logic [N-1:0]  step_lo;
    logic          accept;
    logic          last;

    // One step: add M if the current multiplier bit is set, keeping the
    // carry, then shift the whole {carry, H, L} right by one.
    always_comb begin
        addend  = acc_lo[0] ? mcand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        step_hi = sum[N:1];
        step_lo = {sum[0], acc_lo[N-1:1]};
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == BUSY) && (count == CW'(1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (count == CW'(1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else if (accept) begin
            mcand  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            count  <= CW'(N);
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - CW'(1);
        end
    end

    // Results move only on the final step, so they hold the previous
    // product for the whole busy period.
    always_ff @(posedge clock) begin
        if (reset) begin
            product_hi <= '0;
            product_lo <= '0;
        end else if (last) begin
            product_hi <= step_hi;
            product_lo <= step_lo;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors and multi-cycle corner sequences
// for seq_multiplier (64-bit operands).
module tb_seq_multiplier;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        busy;
    logic        done;
    logic [63:0] product_lo;
    logic [63:0] product_hi;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.N(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%032h expected 0x%032h", name, act, exp);
        end
    endtask

    // Called at a falling edge; drives start for one cycle and returns at
    // the falling edge where done is seen (or when the budget runs out).
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          output int lat, output int nbusy,
                          output logic [127:0] held);
        A     = a;
        B     = b;
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        @(negedge clock);
        start = 1'b0;
        A     = {$urandom, $urandom};
        B     = {$urandom, $urandom};
        lat   = 1;
        held  = {product_hi, product_lo};
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            @(negedge clock);
            lat++;
        end
    endtask

    int           lat;
    int           nbusy;
    int           ndone;
    int           first_done;
    logic [127:0] held;
    logic [127:0] prev;

    initial begin
        vecs[0] = '{"basic_3x5", 64'd3, 64'd5, 128'd15};
        vecs[1] = '{"max_ops", 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF,
                    {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}};
        vecs[2] = '{"zero_a", 64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0};
        vecs[3] = '{"msb_x2", 64'h8000_0000_0000_0000, 64'd2,
                    {64'd1, 64'd0}};
        vecs[4] = '{"max_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                    {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}};
        vecs[5] = '{"x16", 64'h1234_5678_9ABC_DEF0, 64'h10,
                    {64'd1, 64'h2345_6789_ABCD_EF00}};
        vecs[6] = '{"ffff_sq", 64'hFFFF, 64'hFFFF, 128'hFFFE_0001};
        vecs[7] = '{"one_x", 64'd1, 64'hDEAD_BEEF_0000_0001,
                    {64'd0, 64'hDEAD_BEEF_0000_0001}};

        reset = 1'b1;
        start = 1'b1;
        A     = 64'd5;
        B     = 64'd5;
        repeat (2) @(negedge clock);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_prod", {product_hi, product_lo}, 128'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("idle_busy", {127'd0, busy}, 128'd0);

        prev = 128'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk({vecs[i].name, "_idle"}, {127'd0, done}, 128'd0);
            run_op(vecs[i].a, vecs[i].b, lat, nbusy, held);
            chk({vecs[i].name, "_lat"}, 128'(lat), 128'd65);
            chk({vecs[i].name, "_nbusy"}, 128'(nbusy), 128'd64);
            chk({vecs[i].name, "_hold"}, held, prev);
            chk({vecs[i].name, "_prod"}, {product_hi, product_lo},
                vecs[i].p);
            prev = vecs[i].p;
        end

        // Start pulse while busy must be ignored.
        @(negedge clock);
        A     = 64'd7;
        B     = 64'd6;
        start = 1'b1;
        ndone      = 0;
        first_done = 0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 10) begin
                A     = 64'd9;
                B     = 64'd9;
                start = 1'b1;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        chk("sb_ndone", 128'(ndone), 128'd1);
        chk("sb_lat", 128'(first_done), 128'd65);
        chk("sb_prod", {product_hi, product_lo}, 128'd42);
        chk("sb_idle_busy", {127'd0, busy}, 128'd0);

        // Back-to-back: second start lands in the DONE cycle.
        @(negedge clock);
        run_op(64'd10, 64'd10, lat, nbusy, held);
        chk("b2b_hold42", held, 128'd42);
        chk("b2b_lat1", 128'(lat), 128'd65);
        chk("b2b_prod1", {product_hi, product_lo}, 128'd100);
        run_op(64'd2, 64'd3, lat, nbusy, held);
        chk("b2b_hold100", held, 128'd100);
        chk("b2b_lat2", 128'(lat), 128'd65);
        chk("b2b_nbusy2", 128'(nbusy), 128'd64);
        chk("b2b_prod2", {product_hi, product_lo}, 128'd6);

        // Reset in the middle of an operation aborts it.
        @(negedge clock);
        A     = 64'hFFFF;
        B     = 64'hFFFF;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_prod", {product_hi, product_lo}, 128'd0);
        ndone = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            if (done || busy) ndone++;
        end
        chk("rst_no_done", 128'(ndone), 128'd0);
        run_op(64'd4, 64'd4, lat, nbusy, held);
        chk("rst_hold0", held, 128'd0);
        chk("rst_lat", 128'(lat), 128'd65);
        chk("rst_prod16", {product_hi, product_lo}, 128'd16);
        @(negedge clock);
        chk("rst_done_pulse", {127'd0, done}, 128'd0);
        chk("rst_prod_keep", {product_hi, product_lo}, 128'd16);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
